// File: rtl/fft_pkg.sv
// Shared definitions for the parallel-lane FFT cores and their checkers.
//   - default data-path geometry (component width, lanes, points per frame)
//   - derived beat / index widths
//   - checker FSM state encodings
//   - lane_lsb(): bit offset of lane k inside a packed {re, im} lane vector
package fft_pkg;

    localparam int NBITS_OUT_DEF = 10;
    localparam int LANES_DEF     = 4;
    localparam int N_DEF         = 128;
    localparam int BEATS_DEF     = N_DEF / LANES_DEF;
    localparam int IDX_W_DEF     = (BEATS_DEF > 1) ? $clog2(BEATS_DEF) : 1;
    localparam int LN_W_DEF      = (LANES_DEF > 1) ? $clog2(LANES_DEF) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } chk_state_t;

    // Lane k occupies bits [(k+1)*2*nbits-1 : k*2*nbits].
    function automatic int lane_lsb(input int lane, input int nbits);
        return lane * 2 * nbits;
    endfunction

endpackage

// File: rtl/fft_align_delay.sv
// Runtime-programmable alignment delay: a MAX_LAT-entry circular buffer.
// A sample presented at cycle t appears on the outputs at cycle t+lat.
// lat=0 is a pure combinational bypass.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             drop every stored valid bit (data is left in the RAM)
//   lat             delay in cycles, 0..MAX_LAT (caller clamps)
//   in_valid/data   sample written this cycle
//   out_valid/data  sample written lat cycles ago
module fft_align_delay #(
    parameter int WIDTH   = 80,
    parameter int MAX_LAT = 64,
    parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [LAT_W-1:0] lat,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    localparam int PTR_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    logic [WIDTH-1:0]   mem [MAX_LAT];
    logic [MAX_LAT-1:0] vld_reg;
    logic [PTR_W-1:0]   wp_reg;
    logic [PTR_W-1:0]   rd_addr;
    logic [PTR_W:0]     rd_base;
    logic [PTR_W:0]     rd_lat;
    logic [PTR_W:0]     rd_calc;
    logic               rd_valid_reg;
    logic [WIDTH-1:0]   rd_data_reg;

    // The read is registered, so address the entry that will be lat cycles
    // old on the next cycle: (wp + 1 - lat) mod MAX_LAT.
    always_comb begin
        rd_base = (PTR_W+1)'(wp_reg) + (PTR_W+1)'(1);
        rd_lat  = (lat == '0) ? (PTR_W+1)'(1) : (PTR_W+1)'(lat);
        if (rd_base >= rd_lat) begin
            rd_calc = rd_base - rd_lat;
        end else begin
            rd_calc = rd_base + (PTR_W+1)'(MAX_LAT) - rd_lat;
        end
        rd_addr = PTR_W'(rd_calc);
    end

    // Data RAM: no reset, registered read with write-through for lat=1.
    always_ff @(posedge clk) begin
        mem[wp_reg] <= in_data;
        rd_data_reg <= (rd_addr == wp_reg) ? in_data : mem[rd_addr];
    end

    // Valid bits live in flops so they can be wiped in one cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld_reg      <= '0;
            rd_valid_reg <= 1'b0;
            wp_reg       <= '0;
        end else begin
            vld_reg[wp_reg] <= in_valid;
            rd_valid_reg    <= (rd_addr == wp_reg) ? in_valid : vld_reg[rd_addr];
            wp_reg          <= (wp_reg == PTR_W'(MAX_LAT - 1)) ? '0 : wp_reg + PTR_W'(1);
        end
    end

    assign out_valid = (lat == '0) ? in_valid : rd_valid_reg;
    assign out_data  = (lat == '0) ? in_data  : rd_data_reg;

endmodule

// File: rtl/fft_stream_checker.sv
// Stream checker for parallel-lane FFT outputs: delays the golden stream by a
// programmable latency and compares it lane by lane with the DUT output,
// counting beats, frames and mismatched lanes and recording the first error.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             arm / restart (captures cfg_latency)
//   cfg_latency       alignment delay, clamped to MAX_LAT
//   stop_on_err       enter HALT after the first mismatching beat
//   exp_valid/data    golden samples
//   dut_data          DUT samples, same packing
//   cmp_valid         registered compare result valid
//   lane_match        per-lane equality of that compare
//   mismatch_cnt      mismatched lanes since start, saturating
//   frame_cnt         completed frames since start, saturating
//   frame_err         pulse with the last beat of a frame that had a mismatch
//   first_err_*       frame / beat / lowest lane of the first mismatch
//   err_seen          sticky mismatch flag
//   state             FSM state code
module fft_stream_checker import fft_pkg::*; #(
    parameter int NBITS_out = NBITS_OUT_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int N         = N_DEF,
    parameter int MAX_LAT   = 64,
    parameter int CNT_W     = 16,
    localparam int BEATS    = N / LANES,
    localparam int LAT_W    = $clog2(MAX_LAT + 1),
    localparam int IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int LN_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [LAT_W-1:0]             cfg_latency,
    input  logic                         stop_on_err,
    input  logic                         exp_valid,
    input  logic [LANES*2*NBITS_out-1:0] exp_data,
    input  logic [LANES*2*NBITS_out-1:0] dut_data,
    output logic                         cmp_valid,
    output logic [LANES-1:0]             lane_match,
    output logic [CNT_W-1:0]             mismatch_cnt,
    output logic [CNT_W-1:0]             frame_cnt,
    output logic                         frame_err,
    output logic [CNT_W-1:0]             first_err_frame,
    output logic [IDX_W-1:0]             first_err_idx,
    output logic [LN_W-1:0]              first_err_lane,
    output logic                         err_seen,
    output logic [1:0]                   state
);
    localparam int DW = LANES * 2 * NBITS_out;
    localparam int LW = 2 * NBITS_out;

    chk_state_t       state_reg, state_next;
    logic [LAT_W-1:0] lat_clamped, lat_reg, fill_cnt_reg;
    logic             al_valid;
    logic [DW-1:0]    al_data;
    logic [LANES-1:0] eq;
    logic             check_en, any_mis, last_beat;
    logic [LN_W:0]    mis_pop;
    logic [LN_W-1:0]  low_lane;
    logic [CNT_W:0]   mis_sum;

    logic             cmp_valid_reg, frame_err_reg, err_seen_reg, frame_bad_reg;
    logic [LANES-1:0] lane_match_reg;
    logic [CNT_W-1:0] mis_cnt_reg, frame_cnt_reg, ef_frame_reg;
    logic [IDX_W-1:0] beat_idx_reg, ef_idx_reg;
    logic [LN_W-1:0]  ef_lane_reg;

    assign lat_clamped = (cfg_latency > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : cfg_latency;

    fft_align_delay #(
        .WIDTH   (DW),
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .lat       (lat_reg),
        .in_valid  (exp_valid),
        .in_data   (exp_data),
        .out_valid (al_valid),
        .out_data  (al_data)
    );

    // Equality via an if: an X/Z compare result falls to the else branch in
    // simulation and is therefore reported as a mismatch.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic eq_l;
        always_comb begin
            eq_l = 1'b0;
            if (al_data[lane_lsb(gi, NBITS_out) +: LW] == dut_data[lane_lsb(gi, NBITS_out) +: LW]) begin
                eq_l = 1'b1;
            end
        end
        assign eq[gi] = eq_l;
    end

    // Popcount of failing lanes and the lowest failing lane.
    always_comb begin
        mis_pop  = '0;
        low_lane = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (!eq[k]) begin
                mis_pop  = mis_pop + (LN_W+1)'(1);
                low_lane = LN_W'(k);
            end
        end
    end

    assign any_mis   = ~&eq;
    assign last_beat = (beat_idx_reg == IDX_W'(BEATS - 1));
    assign mis_sum   = {1'b0, mis_cnt_reg} + (CNT_W+1)'(mis_pop);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state. start re-arms from any state.
    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = (lat_clamped == '0) ? ST_CHECK : ST_FILL;
        end else begin
            case (state_reg)
                ST_FILL:  if (fill_cnt_reg <= LAT_W'(1)) state_next = ST_CHECK;
                ST_CHECK: if (check_en && any_mis && stop_on_err) state_next = ST_HALT;
                default:  state_next = state_reg;
            endcase
        end
    end

    // FSM: outputs. A start cycle never counts as a compare.
    always_comb begin
        check_en = (state_reg == ST_CHECK) && al_valid && !start;
    end

    // Counters, first-error capture and registered compare results.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_reg        <= '0;
            fill_cnt_reg   <= '0;
            cmp_valid_reg  <= 1'b0;
            lane_match_reg <= '0;
            frame_err_reg  <= 1'b0;
            mis_cnt_reg    <= '0;
            frame_cnt_reg  <= '0;
            beat_idx_reg   <= '0;
            frame_bad_reg  <= 1'b0;
            err_seen_reg   <= 1'b0;
            ef_frame_reg   <= '0;
            ef_idx_reg     <= '0;
            ef_lane_reg    <= '0;
        end else begin
            cmp_valid_reg <= check_en;
            frame_err_reg <= 1'b0;
            if (start) begin
                lat_reg        <= lat_clamped;
                fill_cnt_reg   <= lat_clamped;
                lane_match_reg <= '0;
                mis_cnt_reg    <= '0;
                frame_cnt_reg  <= '0;
                beat_idx_reg   <= '0;
                frame_bad_reg  <= 1'b0;
                err_seen_reg   <= 1'b0;
                ef_frame_reg   <= '0;
                ef_idx_reg     <= '0;
                ef_lane_reg    <= '0;
            end else begin
                if (state_reg == ST_FILL) begin
                    fill_cnt_reg <= fill_cnt_reg - LAT_W'(1);
                end
                if (check_en) begin
                    lane_match_reg <= eq;
                    mis_cnt_reg    <= mis_sum[CNT_W] ? '1 : mis_sum[CNT_W-1:0];
                    if (any_mis && !err_seen_reg) begin
                        err_seen_reg <= 1'b1;
                        ef_frame_reg <= frame_cnt_reg;
                        ef_idx_reg   <= beat_idx_reg;
                        ef_lane_reg  <= low_lane;
                    end
                    if (last_beat) begin
                        beat_idx_reg  <= '0;
                        frame_cnt_reg <= (frame_cnt_reg == '1) ? frame_cnt_reg : frame_cnt_reg + CNT_W'(1);
                        frame_err_reg <= frame_bad_reg | any_mis;
                        frame_bad_reg <= 1'b0;
                    end else begin
                        beat_idx_reg  <= beat_idx_reg + IDX_W'(1);
                        frame_bad_reg <= frame_bad_reg | any_mis;
                    end
                end
            end
        end
    end

    assign cmp_valid       = cmp_valid_reg;
    assign lane_match      = lane_match_reg;
    assign mismatch_cnt    = mis_cnt_reg;
    assign frame_cnt       = frame_cnt_reg;
    assign frame_err       = frame_err_reg;
    assign first_err_frame = ef_frame_reg;
    assign first_err_idx   = ef_idx_reg;
    assign first_err_lane  = ef_lane_reg;
    assign err_seen        = err_seen_reg;
    assign state           = state_reg;

endmodule
